rx_frame_reader: RTL

RX_FRAME_READER -- requirements
Module: rx_frame_reader

---
 rtl/rx_frame_reader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_reader.sv
// Rx frame reader: pairs each frame-queue length with the rx data FIFO words,
// rewrites the two pad bytes with the payload length, trims CRC and drops empty frames.
module rx_frame_reader #(
    parameter int STRIP_CRC = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [35:0] rxff_dout,
    input  logic        rxff_empty,
    output logic        rxff_re,
    input  logic [13:0] rfq_dout,
    input  logic        rfq_empty,
    output logic        rfq_re,
    output logic [31:0] fr_data,
    output logic        fr_valid,
    input  logic        fr_ready,
    output logic        fr_sof,
    output logic        fr_eof,
    output logic [1:0]  fr_nbytes,
    output logic [15:0] drop_count,
    output logic [15:0] len_err_count
);
    typedef enum logic [2:0] {IDLE, LOAD, DATA, FLUSH, DISCARD} state_e;

    // Bytes counted beyond the payload: 2 pad bytes, plus the CRC when it is forwarded.
    localparam logic [13:0] EXTRA_BYTES = (STRIP_CRC != 0) ? 14'd2 : 14'd6;

    state_e      state_q, state_d;
    logic [13:0] len_q, len_d;
    logic [13:0] tgt_q, tgt_d;
    logic [13:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [1:0]  nb_q, nb_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] lerr_q, lerr_d;
    logic        rxff_re_c, rfq_re_c;

    logic [31:0] word_bytes;
    logic [3:0]  eof_flags;
    logic        any_eof;
    logic [1:0]  eof_nb;
    logic [13:0] cnt_next;
    logic        out_free;

    assign word_bytes = {rxff_dout[34:27], rxff_dout[25:18], rxff_dout[16:9], rxff_dout[7:0]};
    assign eof_flags  = {rxff_dout[35], rxff_dout[26], rxff_dout[17], rxff_dout[8]};
    assign any_eof    = |eof_flags;
    assign cnt_next   = cnt_q + 14'd4;
    assign out_free   = !valid_q || fr_ready;

    // Valid bytes in a word whose earliest eof flag is at byte position p: (p+1) mod 4.
    always_comb begin
        eof_nb = 2'd0;
        if (eof_flags[3])      eof_nb = 2'd1;
        else if (eof_flags[2]) eof_nb = 2'd2;
        else if (eof_flags[1]) eof_nb = 2'd3;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        data_d    = data_q;
        valid_d   = valid_q && !fr_ready;
        sof_d     = sof_q;
        eof_d     = eof_q;
        nb_d      = nb_q;
        drop_d    = drop_q;
        lerr_d    = lerr_q;
        rxff_re_c = 1'b0;
        rfq_re_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rfq_empty) begin
                    rfq_re_c = 1'b1;
                    len_d    = rfq_dout;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (len_q == 14'd0) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    state_d = DISCARD;
                end else begin
                    tgt_d   = len_q + EXTRA_BYTES;
                    cnt_d   = 14'd0;
                    first_d = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!rxff_empty && out_free) begin
                    rxff_re_c = 1'b1;
                    cnt_d     = cnt_next;
                    first_d   = 1'b0;
                    valid_d   = 1'b1;
                    sof_d     = first_q;
                    data_d    = first_q ? {2'b00, len_q, word_bytes[15:0]} : word_bytes;
                    eof_d     = 1'b0;
                    nb_d      = 2'd0;
                    if (cnt_next >= tgt_q) begin
                        eof_d   = 1'b1;
                        nb_d    = tgt_q[1:0];
                        state_d = any_eof ? IDLE : FLUSH;
                    end else if (any_eof) begin
                        // Stream ended short of the queued length: close the frame here.
                        eof_d   = 1'b1;
                        nb_d    = eof_nb;
                        if (lerr_q != 16'hFFFF) lerr_d = lerr_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            FLUSH, DISCARD: begin
                if (!rxff_empty) begin
                    rxff_re_c = 1'b1;
                    if (any_eof) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            nb_q    <= '0;
            drop_q  <= '0;
            lerr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            nb_q    <= nb_d;
            drop_q  <= drop_d;
            lerr_q  <= lerr_d;
        end
    end

    // FIFO pops are combinational on the FWFT empty flags and held off while in reset.
    assign rxff_re       = rxff_re_c && reset_n;
    assign rfq_re        = rfq_re_c && reset_n;
    assign fr_data       = data_q;
    assign fr_valid      = valid_q;
    assign fr_sof        = sof_q;
    assign fr_eof        = eof_q;
    assign fr_nbytes     = nb_q;
    assign drop_count    = drop_q;
    assign len_err_count = lerr_q;
endmodule
